sdram_pixel_reader: RTL and testbench
=====================================

// Module: sdram_pixel_reader
// PURPOSE
//  Avalon-MM pipelined read master that fetches a contiguous run of 16-bit pixels
//  (RGB565) from the SDRAM controller slave of the image-processing system.
//  Buffers the returned words in an internal FIFO and presents them as a
//  valid/ready pixel stream to a hardware filter stage.
//  Sits between the system interconnect (SDRAM controller) and the filter datapath.
// PARAMETERS
//  ADDR_W      32  Avalon byte-address width
//  COUNT_W     24  width of word_count and internal issue/receive counters
//  FIFO_DEPTH  16  return-data FIFO entries; power of 2, >= 4
// PORTS
//  clk_clk            in   1        system clock, all logic on rising edge
//  reset_reset_n      in   1        asynchronous active-low reset
//  start              in   1        1-cycle pulse: begin transfer (ignored while busy=1)
//  base_addr          in   ADDR_W   byte address of first pixel, sampled on start; bit0 ignored
//  word_count         in   COUNT_W  number of 16-bit words to read, sampled on start
//  busy               out  1        transfer in progress
//  done               out  1        1-cycle pulse when last word has left the stream port
//  avm_address        out  ADDR_W   read byte address
//  avm_read           out  1        read request
//  avm_waitrequest    in   1        slave stall; request held while high
//  avm_readdata       in   16       returned data
//  avm_readdatavalid  in   1        returned-data strobe, in request order
//  pix_data           out  16       stream data (FIFO head)
//  pix_valid          out  1        FIFO non-empty
//  pix_ready          in   1        consumer accepts when pix_valid & pix_ready
// BEHAVIOUR
//  Reset: busy=0, done=0, avm_read=0, avm_address=0, pix_valid=0, FIFO empty,
//   all counters 0, state IDLE. Reset mid-transfer aborts at once; late
//   readdatavalid after reset is not expected (system reset also resets SDRAM ctrl).
//  FSM IDLE -> ISSUE -> WAIT -> DRAIN -> IDLE.
//   IDLE: start & word_count!=0 -> latch addr={base_addr[ADDR_W-1:1],1'b0}, count;
//    busy=1 next cycle; ISSUE. start & word_count==0 -> done=1 next cycle, stay IDLE.
//   ISSUE: avm_read=1 when issued<count and outstanding+fifo_level<FIFO_DEPTH
//    (credit rule: FIFO never overflows). Request accepted when avm_read &
//    !avm_waitrequest: issued++, outstanding++, avm_address+=2. While
//    waitrequest=1 avm_read/avm_address held stable; request never withdrawn.
//    Last request accepted -> WAIT, avm_read=0 same edge.
//   WAIT: received==count -> DRAIN.
//   DRAIN: FIFO empty -> done=1 one cycle, busy=0, IDLE.
//  readdatavalid: push avm_readdata, received++, outstanding-- (any state but IDLE).
//  Simultaneous accept + readdatavalid: outstanding unchanged.
//  Simultaneous push + pop: fifo_level unchanged; pop of sole entry with push
//   keeps pix_valid=1. FIFO pointers wrap modulo FIFO_DEPTH.
//  Latency: first avm_read asserted 1 cycle after start; pixel visible on
//   pix_data the cycle after its readdatavalid.
//  avm_address wraps modulo 2^ADDR_W; counters are COUNT_W bits, no overflow
//   since issued/received <= count.
//  pix_data stable while pix_valid & !pix_ready.
// CONFIGURATION
//  RGB565_TO_GRAY_EN defined: pix_data = {8'h00, Y}, computed combinationally
//   from FIFO head w: R8={w[15:11],w[15:13]}, G8={w[10:5],w[10:9]},
//   B8={w[4:0],w[4:2]}; Y=(77*R8+150*G8+29*B8)>>8 (18-bit sum, truncate).
//  Undefined: pix_data = raw FIFO head word. Handshake/timing identical both ways.
// TESTING
//  1 start base=0x100,count=8, no stalls, pix_ready=1 -> addrs 0x100..0x10E, 8
//    words out in order, done pulses once, busy falls same edge.
//  2 count=40, pix_ready=0 -> exactly FIFO_DEPTH(16) reads issued then
//    avm_read=0; release ready -> all 40 delivered, no loss/duplication.
//  3 random waitrequest and 0-5 cycle readdatavalid latency -> address/read
//    stable under stall, data order preserved, outstanding never >16.
//  4 start with count=0 -> no avm_read, done=1 next cycle; start while busy ignored.
//  5 reset_reset_n low mid-ISSUE -> all outputs reset values immediately;
//    new start after release runs clean transfer.
//  6 RGB565_TO_GRAY_EN: words 0xFFFF,0xF800,0x07E0,0x0000 -> pix_data
//    0x00FF,0x004C,0x0095,0x0000.

Source files
------------

// File: rtl/sdram_pixel_reader.sv
// sdram_pixel_reader: Avalon-MM pipelined read master -> credit-protected FIFO -> valid/ready RGB565 pixel stream.
// Optional macro RGB565_TO_GRAY_EN replaces the stream word with {8'h00, luma}.
`default_nettype none

module sdram_pixel_reader #(
  parameter int ADDR_W     = 32,
  parameter int COUNT_W    = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [15:0]        avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [15:0]        pix_data,
  output logic               pix_valid,
  input  logic               pix_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               read_q;
  logic               busy_q;
  logic               done_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] issued_q;
  logic [COUNT_W-1:0] received_q;
  logic [LVL_W-1:0]   outstanding_q;
  logic [LVL_W-1:0]   level_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [15:0]        mem_q [FIFO_DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic [COUNT_W-1:0] issued_d;
  logic [LVL_W-1:0]   outstanding_d;
  logic [LVL_W-1:0]   level_d;
  logic               credit_ok;
  logic               read_d;
  logic [15:0]        head;

  assign accept = read_q & ~avm_waitrequest;
  assign push   = avm_readdatavalid & (state_q != S_IDLE);
  assign pop    = (level_q != '0) & pix_ready;

  // Credit is evaluated on next-cycle occupancy so the registered avm_read
  // never requests a word that could find the FIFO full when it returns.
  always_comb begin
    issued_d      = issued_q + COUNT_W'(accept);
    outstanding_d = outstanding_q + LVL_W'(accept) - LVL_W'(push);
    level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
    credit_ok     = ((LVL_W+1)'(outstanding_d) + (LVL_W+1)'(level_d)) < (LVL_W+1)'(FIFO_DEPTH);
    read_d        = (read_q & avm_waitrequest) | ((issued_d < count_q) & credit_ok);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      read_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      level_q       <= level_d;
      if (push) begin
        received_q <= received_q + COUNT_W'(1);
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              addr_q     <= base_addr & ~ADDR_W'(1);
              count_q    <= word_count;
              issued_q   <= '0;
              received_q <= '0;
              busy_q     <= 1'b1;
              read_q     <= 1'b1;
              state_q    <= S_ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          read_q   <= read_d;
          issued_q <= issued_d;
          if (accept) begin
            addr_q <= addr_q + ADDR_W'(2);
          end
          if (issued_d == count_q) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (received_q == count_q) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (level_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= avm_readdata;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;
  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign pix_valid   = (level_q != '0);

`ifdef RGB565_TO_GRAY_EN
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [17:0] ysum;

  assign r8       = {head[15:11], head[15:13]};
  assign g8       = {head[10:5], head[10:9]};
  assign b8       = {head[4:0], head[4:2]};
  assign ysum     = 18'd77 * {10'd0, r8} + 18'd150 * {10'd0, g8} + 18'd29 * {10'd0, b8};
  assign pix_data = {8'h00, 8'(ysum >> 8)};
`else
  assign pix_data = head;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_pixel_reader.sv
// tb_sdram_pixel_reader: randomized Avalon slave + transaction-level reference model for sdram_pixel_reader.
`default_nettype none

module tb_sdram_pixel_reader;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] word_count = '0;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        wr = 1'b0;
  logic [15:0] rdata = '0;
  logic        rdv = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rsp_data[$];
  int          rsp_due[$];

  always #5 clk = ~clk;

  sdram_pixel_reader #(.ADDR_W(32), .COUNT_W(24), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (wr),
    .avm_readdata      (rdata),
    .avm_readdatavalid (rdv),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory contents: a few fixed colour words, otherwise an address hash.
  function automatic logic [15:0] sdram_word(input logic [31:0] a);
    case (a)
      32'h4000: return 16'hFFFF;
      32'h4002: return 16'hF800;
      32'h4004: return 16'h07E0;
      32'h4006: return 16'h0000;
      default:  return a[16:1] ^ a[31:16] ^ 16'hC35A;
    endcase
  endfunction

  function automatic logic [15:0] expect_pixel(input logic [15:0] w);
`ifdef RGB565_TO_GRAY_EN
    int r, g, b, y;
    r = (int'(w) >> 11) & 31;
    g = (int'(w) >> 5) & 63;
    b = int'(w) & 31;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    y = (77 * r + 150 * g + 29 * b) / 256;
    return 16'(y);
`else
    return w;
`endif
  endfunction

  // One transfer: drives the slave and consumer at each negedge and checks
  // the DUT against counts of issued/returned/consumed words.
  task automatic run_transfer(input logic [31:0] base, input int cnt, input int stall_pct,
                              input int max_lat, input int ready_pct, input int hold,
                              input int restart_at, input int abort_at);
    logic [31:0] base_al;
    logic [31:0] exp_addr;
    logic [31:0] prev_addr;
    int          issued, rcvd, popped, cyc, level;
    bit          prev_stall, finished, accept;
    base_al    = base & ~32'd1;
    exp_addr   = base_al;
    prev_addr  = '0;
    issued     = 0;
    rcvd       = 0;
    popped     = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    finished   = 1'b0;
    rsp_data.delete();
    rsp_due.delete();

    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    start      = 1'b1;
    base_addr  = base;
    word_count = 24'(cnt);
    @(negedge clk);
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = 24'($urandom);

    if (cnt == 0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_read", avm_read, 0);
      @(negedge clk);
      check_eq("zero_done_pulse", done, 0);
      check_eq("zero_read2", avm_read, 0);
      return;
    end
    check_eq("busy_rise", busy, 1);
    check_eq("first_read", avm_read, 1);

    while (!finished && cyc < 4000) begin
      if (abort_at != 0 && cyc == abort_at) return;
      if (done) begin
        check_eq("done_all_popped", 32'(popped), 32'(cnt));
        check_eq("done_busy_low", busy, 0);
        finished = 1'b1;
      end else begin
        level = rcvd - popped;
        check_eq("pix_valid", pix_valid, (level != 0));
        if (prev_stall) begin
          check_eq("stall_read_held", avm_read, 1);
          check_eq("stall_addr_held", avm_address, prev_addr);
        end
        if (hold != 0 && cyc == hold) begin
          check_eq("credit_fill_issued", 32'(issued), 32'(DEPTH));
          check_eq("credit_fill_read_low", avm_read, 0);
        end

        wr = ($urandom_range(0, 99) < stall_pct);
        if (rsp_data.size() > 0 && rsp_due[0] <= cyc) begin
          rdv   = 1'b1;
          rdata = rsp_data.pop_front();
          void'(rsp_due.pop_front());
          rcvd++;
        end else begin
          rdv   = 1'b0;
          rdata = 16'($urandom);
        end
        ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        if (restart_at != 0 && cyc == restart_at) begin
          start      = 1'b1;
          base_addr  = 32'h9000;
          word_count = 24'd5;
        end else begin
          start = 1'b0;
        end

        accept     = avm_read & ~wr;
        prev_stall = avm_read & wr;
        prev_addr  = avm_address;
        if (accept) begin
          check_eq("addr", avm_address, exp_addr);
          check_eq("no_over_issue", (issued < cnt), 1);
          check_eq("credit", ((issued - popped) < DEPTH), 1);
          rsp_data.push_back(sdram_word(avm_address));
          rsp_due.push_back(cyc + 1 + $urandom_range(0, max_lat));
          exp_addr = exp_addr + 32'd2;
          issued++;
        end
        if (level != 0 && ready) begin
          check_eq("pix_data", pix_data, expect_pixel(sdram_word(base_al + 32'(2 * popped))));
          popped++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    wr    = 1'b0;
    rdv   = 1'b0;
    ready = 1'b0;
    start = 1'b0;
    if (!finished) begin
      check_eq("timeout", 0, 1);
    end else begin
      check_eq("issued_total", 32'(issued), 32'(cnt));
      @(negedge clk);
      check_eq("done_single_pulse", done, 0);
      check_eq("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_read", avm_read, 0);
    check_eq("rst_addr", avm_address, 0);
    check_eq("rst_valid", pix_valid, 0);
    rst_n = 1'b1;

    run_transfer(32'h100, 8, 0, 0, 100, 0, 0, 0);
    run_transfer(32'h2000, 40, 0, 3, 100, 60, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_transfer($urandom & 32'h00FF_FFFF, $urandom_range(1, 60), 40, 5, 70, 0, 0, 0);
    end
    run_transfer(32'hFFFF_FFF9, 10, 30, 2, 80, 0, 0, 0);
    run_transfer(32'h300, 0, 0, 0, 100, 0, 0, 0);
    run_transfer(32'h400, 12, 20, 2, 60, 0, 3, 0);

    run_transfer(32'h500, 30, 30, 3, 50, 0, 0, 6);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_read", avm_read, 0);
    check_eq("abort_addr", avm_address, 0);
    check_eq("abort_valid", pix_valid, 0);
    wr    = 1'b0;
    rdv   = 1'b0;
    ready = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_transfer(32'h600, 9, 20, 3, 80, 0, 0, 0);

    run_transfer(32'h4000, 4, 0, 0, 100, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
